// File: rtl/sobel_result_reader.sv
// -----------------------------------------------------------------------------
// sobel_result_reader
//
// Streams one Sobel result plane (X, Y or Combine) out of the layer-0 result
// memory in raster order as bytes on a valid/ready interface.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      1-cycle pulse: begin reading plane sel
//   sel[1:0]   plane: 01=X, 10=Y, 11=Combine (00 illegal, start ignored)
//   busy       high from accepted start until the last byte leaves out_*
//   done       1-cycle pulse the cycle after the last output handshake
//   crd        memory read strobe
//   caddr_rd   memory read address
//   csel[1:0]  memory plane select (latched sel, 00 while idle)
//   cdata_rd   read data, sampled on the edge that ends a crd cycle
//   out_valid  out_data/out_addr/out_last valid
//   out_ready  downstream accept
//   out_data   pixel value
//   out_addr   raster address of out_data
//   out_last   high with pixel NPIX-1
//   state_dbg  current FSM state (0=IDLE 1=READ 2=DRAIN 3=DONE)
//
// Handshake: a byte transfers on a rising edge where out_valid and out_ready
// are both high. While out_valid is high and out_ready low, out_data,
// out_addr and out_last hold their values and out_valid stays high.
// -----------------------------------------------------------------------------
module sobel_result_reader #(
   parameter int NPIX       = 65536,
   parameter int AW         = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    sel,
   output logic          busy,
   output logic          done,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   output logic [1:0]    csel,
   input  logic [7:0]    cdata_rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic [AW-1:0] out_addr,
   output logic          out_last,
   output logic [1:0]    state_dbg
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   // Counter carries one extra bit so NPIX-1 compares cleanly even when it
   // is the all-ones value of AW bits.
   localparam logic [AW:0] LAST_ADDR = (AW+1)'(NPIX - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW:0]   addr_cnt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW-1:0] wr_idx;

   // Shift-register FIFO: entry 0 is the head and directly drives out_*, so
   // the outputs come straight from flops.
   logic [7:0]    q_data   [FIFO_DEPTH];
   logic [AW-1:0] q_addr   [FIFO_DEPTH];
   logic          q_last   [FIFO_DEPTH];
   logic [7:0]    q_data_n [FIFO_DEPTH];
   logic [AW-1:0] q_addr_n [FIFO_DEPTH];
   logic          q_last_n [FIFO_DEPTH];

   logic push;
   logic pop;
   logic accept;
   logic last_issue;
   logic crd_next;

   // Read latency is one cycle, so the only read in flight is the one whose
   // strobe is high right now; it lands in the FIFO on the closing edge.
   assign push       = crd;
   assign pop        = out_valid & out_ready;
   assign accept     = (state == S_IDLE) && start && (sel != 2'b00);
   assign last_issue = crd && (addr_cnt == LAST_ADDR);
   assign count_next = count + CW'(push) - CW'(pop);
   assign wr_idx     = count - CW'(pop);

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_READ;
         S_READ:  if (last_issue) state_next = S_DRAIN;
         // Leave DRAIN on the edge that pops the final byte so done lands
         // exactly one cycle after the last handshake.
         S_DRAIN: if (count_next == '0) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Credit rule: issue next cycle only if the FIFO has room once this
   // edge's push/pop settle (nothing else is in flight at that point).
   assign crd_next = (state_next == S_READ) && (count_next < CW'(FIFO_DEPTH));

   always_comb begin
      q_data_n = q_data;
      q_addr_n = q_addr;
      q_last_n = q_last;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (pop && (i < FIFO_DEPTH - 1)) begin
            q_data_n[i] = q_data[i+1];
            q_addr_n[i] = q_addr[i+1];
            q_last_n[i] = q_last[i+1];
         end
         // Write position is measured after the pop has shifted the queue.
         if (push && (CW'(i) == wr_idx)) begin
            q_data_n[i] = cdata_rd;
            q_addr_n[i] = addr_cnt[AW-1:0];
            q_last_n[i] = (addr_cnt == LAST_ADDR);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         crd       <= 1'b0;
         addr_cnt  <= '0;
         csel      <= 2'b00;
         count     <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_data[i] <= '0;
            q_addr[i] <= '0;
            q_last[i] <= 1'b0;
         end
      end else begin
         state     <= state_next;
         busy      <= (state_next == S_READ) || (state_next == S_DRAIN);
         done      <= (state_next == S_DONE);
         crd       <= crd_next;
         count     <= count_next;
         out_valid <= (count_next != '0);
         q_data    <= q_data_n;
         q_addr    <= q_addr_n;
         q_last    <= q_last_n;

         if (accept) begin
            addr_cnt <= '0;
            csel     <= sel;
         end else begin
            // Address stops at NPIX-1 and holds there until the next start.
            if (crd && !last_issue) addr_cnt <= addr_cnt + 1'b1;
            if (state_next == S_IDLE) csel <= 2'b00;
         end
      end
   end

   assign caddr_rd  = addr_cnt[AW-1:0];
   assign out_data  = q_data[0];
   assign out_addr  = q_addr[0];
   assign out_last  = q_last[0];
   assign state_dbg = state;

endmodule

// File: tb/tb_sobel_result_reader.sv
module tb_sobel_result_reader;

   localparam int NPIX = 1024;
   localparam int AW   = 10;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1:0]    sel;
   logic          busy;
   logic          done;
   logic          crd;
   logic [AW-1:0] caddr_rd;
   logic [1:0]    csel;
   logic [7:0]    cdata_rd;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic [AW-1:0] out_addr;
   logic          out_last;
   logic [1:0]    state_dbg;

   int errors;
   int checks;

   sobel_result_reader #(.NPIX(NPIX), .AW(AW), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .start(start), .sel(sel),
      .busy(busy), .done(done), .crd(crd), .caddr_rd(caddr_rd), .csel(csel),
      .cdata_rd(cdata_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
      .state_dbg(state_dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: X and Combine hold a[7:0], Y holds ~a[7:0] so a wrong
   // plane select shows up in the data. Combinational; sampled on the edge
   // closing a crd cycle.
   assign cdata_rd = (csel == 2'b10) ? ~caddr_rd[7:0] : caddr_rd[7:0];

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; sel = 2'b00; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, crd, caddr_rd, csel, out_valid, out_data, out_addr, out_last, state_dbg} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b crd=%b caddr=%0d csel=%b ov=%b od=%0d oa=%0d ol=%b st=%0d, want all zero",
                  busy, done, crd, caddr_rd, csel, out_valid, out_data, out_addr, out_last, state_dbg);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || crd !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b crd=%b st=%0d, want 0 0 0", busy, crd, state_dbg);
      end
   endtask

   // Starts a read of plane s at the current negedge and follows it to done.
   // low_pct: chance out_ready is low per cycle; hold: cycles out_ready is
   // forced low after start; restart_at: cycle to pulse an illegal-while-busy
   // start with sel=10 (-1 for none).
   task automatic run_stream(input logic [1:0] s, input int low_pct, input int hold,
                             input int restart_at, input string name);
      int         cyc;
      int         exp_addr;
      int         issued;
      int         popped;
      bit         got_done;
      bit         stalled;
      logic [7:0]    p_data;
      logic [AW-1:0] p_addr;
      logic          p_last;
      logic [7:0]    exp_data;
      cyc = 0; exp_addr = 0; issued = 0; popped = 0;
      got_done = 1'b0; stalled = 1'b0;
      p_data = '0; p_addr = '0; p_last = 1'b0;
      sel = s; start = 1'b1; out_ready = 1'b0;
      while (!got_done && cyc < 4 * NPIX + 200) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         sel   = (cyc == restart_at) ? 2'b10 : 2'b00;

         checks++;
         if (csel !== s) begin
            errors++;
            $display("FAIL %s csel: cyc=%0d got %b want %b", name, cyc, csel, s);
         end
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== p_data || out_addr !== p_addr || out_last !== p_last) begin
               errors++;
               $display("FAIL %s stall_hold: cyc=%0d got v=%b d=%0d a=%0d l=%b want v=1 d=%0d a=%0d l=%b",
                        name, cyc, out_valid, out_data, out_addr, out_last, p_data, p_addr, p_last);
            end
         end
         if (cyc == 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== '0) begin
               errors++;
               $display("FAIL %s first_valid: got v=%b a=%0d want v=1 a=0", name, out_valid, out_addr);
            end
         end
         if (hold > 0 && cyc == hold) begin
            checks++;
            if (issued != 2 || crd !== 1'b0) begin
               errors++;
               $display("FAIL %s hold_reads: issued=%0d crd=%b want 2 and 0", name, issued, crd);
            end
         end
         if (crd === 1'b1) begin
            checks++;
            if (caddr_rd !== AW'(issued)) begin
               errors++;
               $display("FAIL %s read_addr: got %0d want %0d", name, caddr_rd, issued);
            end
            checks++;
            if (issued - popped >= 2) begin
               errors++;
               $display("FAIL %s credit: read issued with occupancy %0d want <2", name, issued - popped);
            end
            issued++;
         end
         if (done === 1'b1) begin
            got_done = 1'b1;
            checks++;
            if (exp_addr != NPIX || busy !== 1'b0 || issued != NPIX) begin
               errors++;
               $display("FAIL %s done_state: bytes=%0d reads=%0d busy=%b want %0d %0d 0",
                        name, exp_addr, issued, busy, NPIX, NPIX);
            end
            if (low_pct == 0 && hold == 0) begin
               checks++;
               if (cyc != NPIX + 2) begin
                  errors++;
                  $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, NPIX + 2);
               end
            end
         end else begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy: cyc=%0d got %b want 1", name, cyc, busy);
            end
         end

         if (cyc <= hold) out_ready = 1'b0;
         else out_ready = ($urandom_range(0, 99) >= low_pct);

         if (out_valid === 1'b1 && out_ready) begin
            exp_data = (s == 2'b10) ? ~8'(exp_addr) : 8'(exp_addr);
            checks++;
            if (out_addr !== AW'(exp_addr) || out_data !== exp_data || out_last !== (exp_addr == NPIX - 1)) begin
               errors++;
               $display("FAIL %s byte: got a=%0d d=%0d l=%b want a=%0d d=%0d l=%b",
                        name, out_addr, out_data, out_last, exp_addr, exp_data, exp_addr == NPIX - 1);
            end
            exp_addr++;
            popped++;
         end
         stalled = (out_valid === 1'b1) && !out_ready;
         p_data = out_data; p_addr = out_addr; p_last = out_last;
      end
      start = 1'b0; sel = 2'b00;
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles, bytes=%0d want %0d", name, cyc, exp_addr, NPIX);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || csel !== 2'b00 || caddr_rd !== AW'(NPIX - 1) ||
          out_valid !== 1'b0 || state_dbg !== 2'd0 || crd !== 1'b0) begin
         errors++;
         $display("FAIL %s after_done: done=%b busy=%b csel=%b caddr=%0d ov=%b st=%0d crd=%b want 0 0 00 %0d 0 0 0",
                  name, done, busy, csel, caddr_rd, out_valid, state_dbg, crd, NPIX - 1);
      end
   endtask

   task automatic test_stream_x();
      run_stream(2'b01, 0, 0, -1, "stream_x");
   endtask

   task automatic test_back_to_back();
      run_stream(2'b10, 0, 0, -1, "b2b_y");
   endtask

   task automatic test_combine_random();
      run_stream(2'b11, 30, 0, -1, "combine_rand");
   endtask

   task automatic test_backpressure();
      run_stream(2'b01, 0, 100, -1, "backpressure");
   endtask

   task automatic test_ignore();
      start = 1'b1; sel = 2'b00;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || crd !== 1'b0 || csel !== 2'b00 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL ignore_sel00: busy=%b crd=%b csel=%b st=%0d want 0 0 00 0", busy, crd, csel, state_dbg);
      end
      run_stream(2'b01, 10, 0, 5, "ignore_restart");
   endtask

   task automatic test_reset_mid();
      int  n;
      bit  saw_done;
      n = 0;
      sel = 2'b01; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; sel = 2'b00;
      while (!(crd === 1'b1 && caddr_rd == AW'(1000)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL reset_mid_reach: address 1000 not reached, caddr=%0d", caddr_rd);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, crd, caddr_rd, csel, out_valid, out_data, out_addr, out_last, state_dbg} !== '0) begin
         errors++;
         $display("FAIL reset_mid_zero: busy=%b done=%b crd=%b caddr=%0d csel=%b ov=%b od=%0d oa=%0d ol=%b want all zero",
                  busy, done, crd, caddr_rd, csel, out_valid, out_data, out_addr, out_last);
      end
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_mid_nodone: done/busy seen after abort, want none");
      end
      run_stream(2'b01, 0, 0, -1, "after_reset");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_stream_x();
      test_back_to_back();
      test_combine_random();
      test_backpressure();
      test_ignore();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
